// File: rtl/data_mem_rmw.sv
// Data-memory responder: byte-addressed loads/stores over a word-only array, sub-word stores via read-modify-write.
// Loads return one cycle after acceptance; mem_busy holds off new requests for the two RMW cycles.
module data_mem_rmw #(
    parameter int DEPTH = 1024
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wr_data,
    input  logic        mem_wr_en,
    input  logic        mem_rd_en,
    input  logic [2:0]  mem_op,
    output logic [31:0] mem_rd_data,
    output logic        mem_rd_valid,
    output logic        mem_busy,
    output logic        mem_misaligned
);
    localparam int AW = $clog2(DEPTH);

    localparam logic [2:0] OP_B  = 3'b000;
    localparam logic [2:0] OP_H  = 3'b001;
    localparam logic [2:0] OP_W  = 3'b010;
    localparam logic [2:0] OP_BU = 3'b100;
    localparam logic [2:0] OP_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, RMW_RD, RMW_WR} state_t;

    state_t state, state_nxt;

    logic [31:0]   mem [DEPTH];

    logic [AW-1:0] idx;
    logic [1:0]    off;
    logic          op_ok;
    logic          aligned;
    logic          req;
    logic          bad;
    logic          do_sw;
    logic          do_sub;
    logic          do_ld;

    logic [AW-1:0] cap_idx;
    logic [31:0]   cap_data;
    logic [2:0]    cap_op;
    logic [1:0]    cap_off;
    logic [31:0]   merge_q;
    logic [31:0]   merged;

    logic          arr_we;
    logic [AW-1:0] arr_waddr;
    logic [31:0]   arr_wdata;

    // Address bits above the word index are don't-care.
    logic unused_addr;
    assign unused_addr = ^mem_addr[31:AW+2];

    assign idx      = mem_addr[AW+1:2];
    assign off      = mem_addr[1:0];
    assign mem_busy = (state != IDLE);

    function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [2:0] op,
                                             input logic [1:0] lane);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{lane, 3'b000} +: 8];
        h = lane[1] ? w[31:16] : w[15:0];
        case (op)
            OP_B:    load_ext = {{24{b[7]}}, b};
            OP_BU:   load_ext = {24'h0, b};
            OP_H:    load_ext = {{16{h[15]}}, h};
            OP_HU:   load_ext = {16'h0, h};
            default: load_ext = w;
        endcase
    endfunction

    always_comb begin
        op_ok   = 1'b0;
        aligned = 1'b0;
        // Unsigned variants have no meaning for stores.
        if (mem_wr_en) begin
            op_ok = (mem_op == OP_B) || (mem_op == OP_H) || (mem_op == OP_W);
        end else begin
            op_ok = (mem_op == OP_B) || (mem_op == OP_H) || (mem_op == OP_W) ||
                    (mem_op == OP_BU) || (mem_op == OP_HU);
        end
        case (mem_op[1:0])
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = (off[0] == 1'b0);
            2'b10:   aligned = (off == 2'b00);
            default: aligned = 1'b0;
        endcase
        req    = (state == IDLE) && (mem_wr_en || mem_rd_en);
        bad    = req && !(op_ok && aligned);
        do_sw  = req && !bad && mem_wr_en && (mem_op == OP_W);
        do_sub = req && !bad && mem_wr_en && (mem_op != OP_W);
        do_ld  = req && !bad && !mem_wr_en && mem_rd_en;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (do_sub) state_nxt = RMW_RD;
            RMW_RD:  state_nxt = RMW_WR;
            RMW_WR:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        merged = merge_q;
        if (cap_op == OP_B) begin
            merged[{cap_off, 3'b000} +: 8] = cap_data[7:0];
        end else if (cap_off[1]) begin
            merged[31:16] = cap_data[15:0];
        end else begin
            merged[15:0] = cap_data[15:0];
        end
    end

    // A reset edge landing in RMW_WR must leave the array untouched.
    always_comb begin
        arr_we    = !Reset && (do_sw || (state == RMW_WR));
        arr_waddr = do_sw ? idx : cap_idx;
        arr_wdata = do_sw ? mem_wr_data : merged;
    end

    always_ff @(posedge Clk) begin
        if (arr_we) begin
            mem[arr_waddr] <= arr_wdata;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state          <= IDLE;
            cap_idx        <= '0;
            cap_data       <= '0;
            cap_op         <= '0;
            cap_off        <= '0;
            merge_q        <= '0;
            mem_rd_data    <= '0;
            mem_rd_valid   <= 1'b0;
            mem_misaligned <= 1'b0;
        end else begin
            state          <= state_nxt;
            mem_rd_valid   <= do_ld;
            mem_misaligned <= bad;
            if (do_ld) begin
                mem_rd_data <= load_ext(mem[idx], mem_op, off);
            end
            if (do_sub) begin
                cap_idx  <= idx;
                cap_data <= mem_wr_data;
                cap_op   <= mem_op;
                cap_off  <= off;
            end
            if (state == RMW_RD) begin
                merge_q <= mem[cap_idx];
            end
        end
    end
endmodule

// File: tb/tb_data_mem_rmw.sv
// Randomized bench for data_mem_rmw with a byte-array reference model and a queue-based scoreboard.
module tb_data_mem_rmw;
    localparam int DEPTH = 64;
    localparam logic [2:0] OP_B  = 3'b000;
    localparam logic [2:0] OP_H  = 3'b001;
    localparam logic [2:0] OP_W  = 3'b010;
    localparam logic [2:0] OP_BU = 3'b100;
    localparam logic [2:0] OP_HU = 3'b101;

    logic        Clk;
    logic        Reset;
    logic [31:0] mem_addr;
    logic [31:0] mem_wr_data;
    logic        mem_wr_en;
    logic        mem_rd_en;
    logic [2:0]  mem_op;
    logic [31:0] mem_rd_data;
    logic        mem_rd_valid;
    logic        mem_busy;
    logic        mem_misaligned;

    data_mem_rmw #(.DEPTH(DEPTH)) dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .mem_addr       (mem_addr),
        .mem_wr_data    (mem_wr_data),
        .mem_wr_en      (mem_wr_en),
        .mem_rd_en      (mem_rd_en),
        .mem_op         (mem_op),
        .mem_rd_data    (mem_rd_data),
        .mem_rd_valid   (mem_rd_valid),
        .mem_busy       (mem_busy),
        .mem_misaligned (mem_misaligned)
    );

    typedef struct {
        int          cyc;
        logic [31:0] data;
    } rd_t;

    rd_t         rd_q[$];
    int          mis_q[$];
    logic [7:0]  mb [DEPTH*4];
    int          cyc = 0;
    int          b_lo = -10;
    int          b_hi = -10;
    logic [31:0] exp_hold = 32'h0;
    bit          mon_en = 1'b0;
    int          checks = 0;
    int          errors = 0;

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    // Reference: request accepted at edge e, effects described in bytes.
    function automatic void model(input int e, input bit wr, input bit rd, input logic [2:0] op,
                                  input logic [31:0] addr, input logic [31:0] data, input bit commit);
        int          size;
        int          ba;
        bit          ok;
        logic [31:0] v;
        rd_t         r;
        if (!wr && !rd) return;
        if (e - 1 >= b_lo && e - 1 <= b_hi) return;
        size = (op[1:0] == 2'b00) ? 1 : (op[1:0] == 2'b01) ? 2 : 4;
        if (wr) ok = (op == OP_B) || (op == OP_H) || (op == OP_W);
        else    ok = (op == OP_B) || (op == OP_H) || (op == OP_W) || (op == OP_BU) || (op == OP_HU);
        if (op[1:0] == 2'b11) ok = 1'b0;
        if (ok && (addr % size) != 0) ok = 1'b0;
        if (!ok) begin
            mis_q.push_back(e);
            return;
        end
        ba = int'(addr % (DEPTH * 4));
        if (wr) begin
            if (commit)
                for (int k = 0; k < size; k++) mb[ba + k] = data[8*k +: 8];
            if (size < 4) begin
                b_lo = e;
                b_hi = e + 1;
            end
        end else begin
            v = 32'h0;
            for (int k = 0; k < size; k++) v = v | (32'(mb[ba + k]) << (8 * k));
            if (!op[2] && size < 4 && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8 * size));
            r.cyc  = e;
            r.data = v;
            rd_q.push_back(r);
        end
    endfunction

    task automatic issue(input bit wr, input bit rd, input logic [2:0] op,
                         input logic [31:0] addr, input logic [31:0] data, input bit commit);
        @(negedge Clk);
        mem_wr_en   = wr;
        mem_rd_en   = rd;
        mem_op      = op;
        mem_addr    = addr;
        mem_wr_data = data;
        model(cyc + 1, wr, rd, op, addr, data, commit);
        @(posedge Clk);
        #1;
        mem_wr_en = 1'b0;
        mem_rd_en = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge Clk);
        while (mem_busy && n < 20) begin
            @(negedge Clk);
            n++;
        end
        if (mem_busy) chk("busy_timeout", {31'h0, mem_busy}, 32'h0);
    endtask

    always @(negedge Clk) begin
        if (mon_en) begin
            rd_t e;
            if (mem_rd_valid) begin
                if (rd_q.size() == 0) begin
                    chk("rd_valid_unexpected", {31'h0, mem_rd_valid}, 32'h0);
                end else begin
                    e = rd_q.pop_front();
                    chk("rd_cycle", cyc, e.cyc);
                    chk("rd_data", mem_rd_data, e.data);
                    exp_hold = e.data;
                end
            end else begin
                chk("rd_hold", mem_rd_data, exp_hold);
                if (rd_q.size() > 0 && rd_q[0].cyc <= cyc) begin
                    chk("rd_valid_missing", {31'h0, mem_rd_valid}, 32'h1);
                    void'(rd_q.pop_front());
                end
            end
            if (mem_misaligned) begin
                if (mis_q.size() == 0) chk("mis_unexpected", {31'h0, mem_misaligned}, 32'h0);
                else chk("mis_cycle", cyc, mis_q.pop_front());
            end else if (mis_q.size() > 0 && mis_q[0] <= cyc) begin
                chk("mis_missing", {31'h0, mem_misaligned}, 32'h1);
                void'(mis_q.pop_front());
            end
            chk("busy", {31'h0, mem_busy}, {31'h0, (cyc >= b_lo && cyc <= b_hi)});
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        Reset       = 1'b1;
        mem_addr    = '0;
        mem_wr_data = '0;
        mem_wr_en   = 1'b0;
        mem_rd_en   = 1'b0;
        mem_op      = OP_W;
        repeat (3) @(posedge Clk);
        #1 Reset = 1'b0;
        @(negedge Clk);
        chk("reset_rd_data", mem_rd_data, 32'h0);
        chk("reset_rd_valid", {31'h0, mem_rd_valid}, 32'h0);
        chk("reset_busy", {31'h0, mem_busy}, 32'h0);
        chk("reset_misaligned", {31'h0, mem_misaligned}, 32'h0);
        mon_en = 1'b1;

        for (int i = 0; i < DEPTH; i++) issue(1, 0, OP_W, 32'(i * 4), $urandom, 1);

        // Word store, immediate reload, then sub-word merges.
        issue(1, 0, OP_W, 32'h10, 32'hDEADBEEF, 1);
        issue(0, 1, OP_W, 32'h10, 32'h0, 1);
        issue(1, 0, OP_B, 32'h12, 32'h5A, 1);
        issue(0, 1, OP_W, 32'h10, 32'h0, 1);
        issue(0, 1, OP_W, 32'h10, 32'h0, 1);
        wait_idle();
        issue(0, 1, OP_W, 32'h10, 32'h0, 1);
        issue(1, 0, OP_H, 32'h10, 32'h1234, 1);
        wait_idle();
        issue(0, 1, OP_W, 32'h10, 32'h0, 1);

        // Extension cases.
        issue(1, 0, OP_W, 32'h20, 32'h80FF7F01, 1);
        issue(0, 1, OP_B,  32'h21, 32'h0, 1);
        issue(0, 1, OP_B,  32'h22, 32'h0, 1);
        issue(0, 1, OP_BU, 32'h23, 32'h0, 1);
        issue(0, 1, OP_H,  32'h22, 32'h0, 1);
        issue(0, 1, OP_HU, 32'h22, 32'h0, 1);

        // Misaligned and invalid.
        issue(0, 1, OP_W,   32'h21, 32'h0, 1);
        issue(1, 0, OP_H,   32'h23, 32'hFFFF, 1);
        issue(0, 1, 3'b011, 32'h20, 32'h0, 1);
        issue(1, 0, OP_BU,  32'h20, 32'h0, 1);
        issue(0, 1, OP_W,   32'h20, 32'h0, 1);

        // Simultaneous store/load and address wrap.
        issue(1, 1, OP_W, 32'h30, 32'h1, 1);
        issue(0, 1, OP_W, 32'h30, 32'h0, 1);
        issue(1, 0, OP_W, 32'(DEPTH * 4 + 32'h50), 32'hCAFEF00D, 1);
        issue(0, 1, OP_W, 32'h50, 32'h0, 1);

        // Reset while the merge is in RMW_WR.
        issue(1, 0, OP_W, 32'h40, 32'h11223344, 1);
        issue(1, 0, OP_B, 32'h40, 32'hAA, 0);
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b1;
        @(posedge Clk);
        #1 Reset = 1'b0;
        exp_hold = 32'h0;
        @(negedge Clk);
        chk("rst_rmw_rd_data", mem_rd_data, 32'h0);
        chk("rst_rmw_rd_valid", {31'h0, mem_rd_valid}, 32'h0);
        chk("rst_rmw_busy", {31'h0, mem_busy}, 32'h0);
        chk("rst_rmw_misaligned", {31'h0, mem_misaligned}, 32'h0);
        issue(0, 1, OP_W, 32'h40, 32'h0, 1);

        for (int i = 0; i < 600; i++) begin
            int          kind;
            logic [2:0]  op;
            logic [31:0] addr;
            kind = $urandom_range(0, 5);
            op   = 3'($urandom_range(0, 7));
            addr = 32'($urandom_range(0, DEPTH * 8 - 1));
            case (kind)
                0:       issue(0, 0, op, addr, $urandom, 1);
                1, 2:    issue(0, 1, op, addr, $urandom, 1);
                3, 4:    issue(1, 0, op, addr, $urandom, 1);
                default: issue(1, 1, op, addr, $urandom, 1);
            endcase
        end

        repeat (5) @(negedge Clk);
        chk("rd_queue_drained", rd_q.size(), 32'h0);
        chk("mis_queue_drained", mis_q.size(), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/data_mem_rmw.md
# data_mem_rmw

Data-memory responder at the far end of the MEM-stage data-memory interface. Accepts byte-addressed load/store requests, returns lane-aligned, sign/zero-extended load data with one-cycle latency, and implements sub-word stores as a read-modify-write over a word-wide storage array with no byte enables. Asserts a stall to the pipeline while a read-modify-write is in flight, and flags misaligned accesses.

## Interface
Parameters:
- DEPTH, 1024, number of 32-bit words; power of two, at least 4.

Ports:
- Clk  in  1  single clock; all state updates on the rising edge.
- Reset  in  1  reset; synchronous, active-high.
- mem_addr  in  32  byte address.
  - Word index is mem_addr[log2(DEPTH)+1:2]; higher bits are ignored.
- mem_wr_data  in  32  store data, unshifted: byte in [7:0], halfword in [15:0].
- mem_wr_en  in  1  store request.
- mem_rd_en  in  1  load request.
- mem_op  in  3  access type:
  - 000 B, 001 H, 010 W, 100 BU, 101 HU.
  - 011, 110 and 111 are invalid.
- mem_rd_data  out  32  load result, lane-shifted and extended.
- mem_rd_valid  out  1  one-cycle pulse; mem_rd_data is valid.
- mem_busy  out  1  read-modify-write in progress; the requester must stall.
- mem_misaligned  out  1  one-cycle pulse; the last accepted request was misaligned or invalid and was dropped.

## Operation
- Storage: DEPTH x 32 array. Contents are not cleared by Reset.
- FSM states: IDLE, RMW_RD, RMW_WR.
- Requests are sampled only in IDLE. Requests presented while mem_busy=1 are ignored.
- mem_wr_en and mem_rd_en asserted together: the store is performed and the load is dropped. mem_rd_valid stays low.
- Alignment rules:
  - H/HU need mem_addr[0]=0.
  - W needs mem_addr[1:0]=00.
  - B/BU are always aligned.
- Misaligned or invalid-op request:
  - No array write, no state change.
  - mem_misaligned=1 for the next cycle.
  - mem_rd_valid stays 0.
- Word store (W, aligned): the array word is written at the accepting edge. FSM stays in IDLE and mem_busy stays 0.
- Sub-word store (B or H; BU/HU on a store are invalid):
  - At the accepting edge, capture word index, mem_wr_data, mem_op and mem_addr[1:0]. Go to RMW_RD.
  - RMW_RD: read the captured word into the merge register. Go to RMW_WR.
  - RMW_WR, merge:
    - B replaces byte lane addr[1:0] with wr_data[7:0].
    - H replaces halfword lane addr[1] with wr_data[15:0].
    - Other bytes are preserved. The merged word is written, then the FSM returns to IDLE.
- Load (aligned, valid op):
  - Word read at the accepting edge.
  - B/BU select byte lane addr[1:0]. H/HU select halfword lane addr[1].
  - B/H sign-extend; BU/HU zero-extend; W returns the word.
- mem_rd_data holds its last value until the next valid load.

## Timing
- Reset values: state IDLE, mem_rd_data 0, mem_rd_valid 0, mem_busy 0, mem_misaligned 0, capture and merge registers 0.
- Load latency: accepted at edge N; mem_rd_data and mem_rd_valid are registered and visible after edge N, for exactly one cycle of valid.
- Back-to-back loads: one per cycle, each producing its own valid pulse.
- Word store latency: 0 stall cycles. A load to the same word in the following cycle returns the new data.
- Sub-word store, accepted at edge N:
  - mem_busy=1 after edge N and after edge N+1.
  - RMW_RD occupies the cycle after edge N; RMW_WR occupies the cycle after edge N+1.
  - Array is written at edge N+2. mem_busy=0 after edge N+2.
  - The earliest following request is accepted at edge N+3 (the first cycle mem_busy reads 0) and observes the merged word.
- mem_busy is registered: it depends only on FSM state, never combinationally on inputs.
- mem_misaligned: registered, high for exactly the cycle after the offending edge.
- Reset asserted in RMW_RD or RMW_WR:
  - The pending merge is aborted; the array word is not modified.
  - After the reset edge: IDLE, mem_busy 0.
- Reset outranks any request in the same cycle: nothing is written or read.
- Address wrap: word index is taken modulo DEPTH. Address DEPTH*4 aliases word 0.

## Test plan
- Word store then load:
  - SW 0xDEADBEEF at 0x10, then LW at 0x10 next cycle.
  - Required: mem_rd_data=0xDEADBEEF with valid one cycle after the load edge; mem_busy never asserts.
- Sub-word store:
  - After word 0x10=0xDEADBEEF, SB 0x5A at 0x12.
  - Required: mem_busy high exactly 2 cycles.
  - Then LW 0x10 returns 0xDE5ABEEF; SH 0x1234 at 0x10, then LW returns 0xDE5A1234.
- Sign/zero extension, with word 0x20=0x80FF7F01:
  - LB 0x21 -> 0x0000007F.
  - LB 0x22 -> 0xFFFFFFFF.
  - LBU 0x23 -> 0x00000080.
  - LH 0x22 -> 0xFFFF80FF.
  - LHU 0x22 -> 0x000080FF.
- Misaligned and invalid:
  - LW 0x21, SH 0x23 and op 011 each give a single mem_misaligned pulse.
  - No mem_rd_valid; array unchanged (LW 0x20 still returns 0x80FF7F01).
- Stall and conflicts:
  - An LW issued while mem_busy=1 produces no valid pulse.
  - Simultaneous wr_en and rd_en with SW 0x1 at 0x30 writes the word with no rd_valid.
- Reset during RMW:
  - SB 0xAA at 0x40 (word 0x11223344); assert Reset in the RMW_WR cycle.
  - Required: all outputs 0 after the edge; LW 0x40 then returns 0x11223344.
